// File: rtl/sar_pkg.sv
// Shared definitions for the SAR4 host-side logic: sequencer state
// encoding, the default result width and the end-of-conversion edge helper.
package sar_pkg;

    localparam int SAR_DATA_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } sar_state_t;

    // A capture is the first cycle eoc is seen high; a held-high eoc yields one event.
    function automatic logic eoc_rise(input logic eoc, input logic eoc_q);
        return eoc & ~eoc_q;
    endfunction

endpackage

// File: rtl/sar_eoc_detect.sv
// End-of-conversion rising-edge detector. The SAR drives eoc on the falling
// clock edge, so registering it on the rising edge gives a clean previous-value
// copy for edge detection.
module sar_eoc_detect
    import sar_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic adc_eoc,
    output logic capture
);

    logic eoc_q;

    // Remember last cycle's eoc so a rising edge can be told apart from a held level.
    always_ff @(posedge clk) begin
        if (reset) begin
            eoc_q <= 1'b0;
        end else begin
            eoc_q <= adc_eoc;
        end
    end

    assign capture = eoc_rise(adc_eoc, eoc_q);

endmodule

// File: rtl/sar_conv_sequencer.sv
// Host-side initiator for the SAR4 converter: requests conversions, captures
// results on eoc rising edges, averages 2^AVG_LOG2 of them and presents the
// average on a valid/ready stream. A watchdog resets a hung converter.
module sar_conv_sequencer
    import sar_pkg::*;
#(
    parameter int DATA_W      = SAR_DATA_W,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int ARST_CYC    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic              cont_en,
    input  logic              err_clr,
    input  logic              adc_eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_start,
    output logic              adc_reset,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int AR_W  = (ARST_CYC > 1) ? $clog2(ARST_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [AR_W-1:0]  AR_LAST  = AR_W'(ARST_CYC - 1);

    sar_state_t        state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [WD_W-1:0]   wd;
    logic [AR_W-1:0]   arst_cnt;
    logic              capture;
    logic              handshake;

    sar_eoc_detect u_eoc_detect (
        .clk     (clk),
        .reset   (reset),
        .adc_eoc (adc_eoc),
        .capture (capture)
    );

    assign handshake = m_valid & m_ready;
    assign busy      = (state != IDLE);

    // Sequencer FSM: conversion requests, accumulation, output load, watchdog and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            wd          <= '0;
            arst_cnt    <= '0;
            adc_start   <= 1'b0;
            adc_reset   <= 1'b1;
            m_valid     <= 1'b0;
            m_data      <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            adc_reset <= 1'b0;

            // Clear first so that a flag set later in this cycle takes priority.
            if (err_clr) begin
                timeout_err <= 1'b0;
                overrun     <= 1'b0;
            end

            if (handshake) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (trig || cont_en) begin
                        state     <= CONV;
                        acc       <= '0;
                        cnt       <= '0;
                        wd        <= '0;
                        adc_start <= 1'b1;
                    end
                end

                CONV: begin
                    // A capture beats a watchdog expiry landing in the same cycle.
                    if (capture) begin
                        acc <= acc + ACC_W'(adc_data);
                        cnt <= cnt + CNT_W'(1);
                        wd  <= '0;
                        if (cnt == CNT_LAST) begin
                            state     <= DONE;
                            adc_start <= 1'b0;
                        end
                    end else if (wd == WD_LAST) begin
                        state       <= TOUT;
                        adc_start   <= 1'b0;
                        adc_reset   <= 1'b1;
                        arst_cnt    <= '0;
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        cnt         <= '0;
                        wd          <= '0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end

                DONE: begin
                    // A fresh word always wins; losing an unaccepted word is flagged.
                    m_data  <= acc[AVG_LOG2 +: DATA_W];
                    m_valid <= 1'b1;
                    if (m_valid && !m_ready) begin
                        overrun <= 1'b1;
                    end
                    if (cont_en) begin
                        state     <= CONV;
                        acc       <= '0;
                        cnt       <= '0;
                        wd        <= '0;
                        adc_start <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                TOUT: begin
                    if (arst_cnt == AR_LAST) begin
                        state <= IDLE;
                    end else begin
                        adc_reset <= 1'b1;
                        arst_cnt  <= arst_cnt + AR_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_conv_sequencer.md
Name: sar_conv_sequencer

Overview:
- Host-side initiator for the SAR4 conversion controller.
- Requests conversions with `adc_start` and detects end-of-conversion on `adc_eoc`.
- Captures the parallel result bits, averages 2^AVG_LOG2 results, and presents each average on a valid/ready stream to the digital back end.
- Adds a watchdog that resets a hung converter and raises sticky error flags.

Parameters:
- DATA_W, 5: width of the SAR result (out4..out0).
- AVG_LOG2, 2: log2 of the number of conversions averaged per output word (0 = no averaging).
- TIMEOUT_CYC, 16: maximum clk cycles allowed in CONV without an eoc rising edge.
- ARST_CYC, 2: number of cycles `adc_reset` is asserted after a timeout.

Ports:
- clk  in  1  Sequencer clock; same net as the SAR clock. Sequencer samples on posedge; SAR updates on negedge.
- reset  in  1  Synchronous, active-high.
- trig  in  1  Single-shot request: one averaged measurement. Accepted only in IDLE.
- cont_en  in  1  Continuous mode: back-to-back averaged measurements while high.
- err_clr  in  1  Clears `timeout_err` and `overrun`.
- adc_eoc  in  1  End-of-conversion from SAR.
- adc_data  in  DATA_W  SAR result; valid while `adc_eoc` is high.
- adc_start  out  1  Conversion request to SAR.
- adc_reset  out  1  Reset to SAR.
- m_valid  out  1  Output word valid.
- m_ready  in  1  Downstream ready.
- m_data  out  DATA_W  Averaged result.
- busy  out  1  High in any state other than IDLE.
- timeout_err  out  1  Sticky: watchdog expired.
- overrun  out  1  Sticky: an output word was overwritten before it was accepted.

Behaviour:
- Reset: state=IDLE. `adc_start`=0, `adc_reset`=1 for the reset cycle, then 0. `m_valid`=0, `m_data`=0, `busy`=0, `timeout_err`=0, `overrun`=0. Accumulator, sample counter, watchdog and `eoc_q` cleared.
- Reset mid-operation: same result. The accumulator is discarded and no partial word is emitted.
- eoc detection: register `adc_eoc` into `eoc_q`. Capture event = `adc_eoc` & ~`eoc_q`, evaluated at posedge. `adc_data` is sampled on the same edge. A held-high eoc produces exactly one capture.
- States:
  - IDLE: if `trig` | `cont_en` -> CONV, with acc=0, cnt=0, wd=0.
  - CONV: `adc_start`=1; wd increments each cycle.
    - On capture: acc += adc_data; cnt += 1; wd=0.
    - If cnt reaches 2^AVG_LOG2 on this capture -> DONE.
    - Otherwise stay in CONV. The SAR free-runs sample->convert, so `adc_start` stays high.
    - If wd == TIMEOUT_CYC-1 and no capture -> TOUT.
  - DONE: `adc_start`=0. Load result = acc >> AVG_LOG2 (truncating) into `m_data`; `m_valid`=1.
    - If `m_valid` was already 1 and not handshaking this cycle, set `overrun` and overwrite.
    - Then: `cont_en` ? CONV (acc, cnt, wd cleared) : IDLE.
  - TOUT: `adc_start`=0; `adc_reset`=1 for ARST_CYC cycles; set `timeout_err`; discard acc; -> IDLE.
- Output handshake: transfer when `m_valid` & `m_ready` at posedge, which clears `m_valid` unless DONE loads a new word in the same cycle (the new word wins, no overrun).
  - `m_data` is stable while `m_valid` & ~`m_ready`, except for an overwrite, which sets `overrun`.
- Widths: accumulator is DATA_W+AVG_LOG2 bits and cannot overflow (max sum 31*4 = 124 < 128).
- Simultaneous events:
  - `trig` outside IDLE is ignored.
  - `cont_en` deassert in CONV completes the current average, then -> IDLE.
  - `err_clr` with a new error in the same cycle: the flag stays set (set wins).
  - Capture and watchdog expiry in the same cycle: capture wins.

Decomposition:
- Shared package `sar_pkg`: state enum (IDLE, CONV, DONE, TOUT), default DATA_W=5, and the eoc edge-detect helper.
- One natural sub-module: `sar_eoc_detect` (eoc_q register plus rising-edge pulse), reusable by other SAR consumers.
- Everything else is flat.

Test Plan:
- Averaging: AVG_LOG2=2, trig pulse, SAR model returns 5, 6, 7, 8 -> one `m_valid` with `m_data`=6 (26>>2); `adc_start` high through all four conversions, then 0; back to IDLE, `busy`=0.
- No averaging: AVG_LOG2=0, `cont_en`=1, results 31, 0, 17 with `m_ready`=1 -> three words 31, 0, 17 in order; no overrun.
- Backpressure: `cont_en`=1, `m_ready`=0 across two averages (9, 12) -> `m_data`=12, `overrun`=1. `err_clr` -> `overrun`=0. `m_ready`=1 -> word 12 transferred.
- Watchdog: TIMEOUT_CYC=16, trig, eoc held low -> 16 cycles after CONV entry: `timeout_err`=1, `adc_reset` high exactly 2 cycles, IDLE, no `m_valid`.
- Stuck-high eoc: eoc held high for 5 cycles during CONV -> exactly one capture, cnt increments by 1.
- Reset mid-CONV after 2 of 4 captures -> all outputs at reset values. A new trig restarts a full 4-sample average; stale samples are excluded (values 1, 1, 1, 1 -> `m_data`=1).
